msrv32_pipe_ctrl: RTL and testbench
===================================

MSRV32_PIPE_CTRL -- requirements
Module: msrv32_pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum data-memory wait cycles before a bus error; legal range 2..255.
REQ-002 Parameter FLUSH_CYCLES, default 1: extra bubble cycles after a taken branch; legal range 0..3.
REQ-003 ms_risc32_mp_clk_in  in  1  clock; all state SHALL update on its rising edge.
REQ-004 ms_risc32_mp_rst_in  in  1  reset, asynchronous, active-high.
REQ-005 branch_taken_in  in  1  execute stage resolved a taken branch or jump this cycle.
REQ-006 ld_use_hazard_in  in  1  decode instruction reads the rd of the load held in stage 2.
REQ-007 dmem_req_in  in  1  stage-2 instruction issues a load or store this cycle.
REQ-008 dmem_ack_in  in  1  data memory completes the outstanding access this cycle.
REQ-009 trap_req_in  in  1  level interrupt/exception request.
REQ-010 reg1_en_out  out  1  PC and fetch/decode register capture enable.
REQ-011 reg2_en_out  out  1  stage-2 pipeline register capture enable.
REQ-012 reg2_flush_out  out  1  stage-2 register loads a bubble (all control fields zero).
REQ-013 pc_sel_out  out  2  next-PC source: 00 pc+4, 01 branch target, 10 trap vector, 11 hold.
REQ-014 trap_taken_out  out  1  one-cycle pulse when the trap vector is selected.
REQ-015 bus_err_out  out  1  one-cycle pulse on memory timeout.
REQ-016 state_out  out  3  current FSM state for debug.

Function
REQ-017 The FSM SHALL have the states RUN=000, LDSTALL=001, MEMWAIT=010, FLUSH=011 and TRAP=100; the outputs are combinational from the state and the inputs, and they follow the state transitions with zero latency.
REQ-018 The "normal" output set is: reg1_en=1, reg2_en=1, flush=0, pc_sel=00, and both pulses 0.
REQ-019 The "trap-entry" output set is: pc_sel=10, trap_taken=1, reg1_en=1, reg2_en=1, flush=1; next state TRAP.
REQ-020 In RUN, events SHALL be handled in priority order trap_req > (dmem_req & !dmem_ack) > branch_taken > ld_use_hazard > none.
REQ-021 RUN with trap_req: trap-entry outputs.
REQ-022 RUN with dmem_req & !dmem_ack: reg1_en=0, reg2_en=0, flush=0, pc_sel=11; wait counter cleared to 0; next state MEMWAIT.
REQ-023 RUN with dmem_req & dmem_ack in the same cycle: normal outputs; the state stays RUN.
REQ-024 RUN with branch_taken: pc_sel=01, reg1_en=1, reg2_en=1, flush=1; next state FLUSH with the flush counter loaded to FLUSH_CYCLES, or next state RUN if FLUSH_CYCLES=0.
REQ-025 RUN with ld_use_hazard: reg1_en=0, reg2_en=1, flush=1, pc_sel=11; next state LDSTALL.
REQ-026 LDSTALL SHALL behave exactly as RUN with ld_use_hazard_in masked to 0, and it SHALL always leave to the state RUN selects, so that at most one bubble is inserted per load.
REQ-027 MEMWAIT: reg1_en=0, reg2_en=0, pc_sel=11; the wait counter increments each cycle; trap_req and branch_taken are ignored.
REQ-028 MEMWAIT with dmem_ack: normal outputs; next state RUN.
REQ-029 MEMWAIT with no ack and wait counter = MEM_TIMEOUT-1: bus_err=1 plus the trap-entry outputs.
REQ-030 MEMWAIT with ack and timeout in the same cycle: the ack wins and no bus error is raised.
REQ-031 FLUSH: reg1_en=1, reg2_en=1, flush=1, pc_sel=00; branch_taken and ld_use_hazard are ignored; the flush counter decrements and the FSM moves to RUN when it reaches 1.
REQ-032 FLUSH with trap_req: trap-entry outputs, overriding the flush sequence.
REQ-033 TRAP: reg1_en=1, reg2_en=1, flush=1, pc_sel=00; trap_req is ignored; next state RUN.
REQ-034 The wait counter SHALL be 8 bits and SHALL saturate, never wrapping.

Reset
REQ-035 While ms_risc32_mp_rst_in=1 the block SHALL force: state RUN, both counters 0, reg1_en=0, reg2_en=0, flush=1, pc_sel=11, trap_taken=0, bus_err=0, state_out=000.
REQ-036 Reset asserted in any state, including MEMWAIT, SHALL abort the operation in progress; after release the FSM starts in RUN with normal outputs unless an input event is present.

Verification
REQ-037 Load-use: assert ld_use_hazard for 2 cycles in RUN -> cycle 1 reg1_en=0, flush=1, pc_sel=11, state_out=001; cycle 2 normal outputs.
REQ-038 Memory wait: dmem_req=1, with dmem_ack arriving 3 cycles later -> reg1_en/reg2_en=0 for 3 cycles, state 010; release in the ack cycle; no bus_err.
REQ-039 Timeout: MEM_TIMEOUT=16 and no ack -> bus_err and trap_taken pulse on MEMWAIT cycle 16 with pc_sel=10; then 1 TRAP cycle (state 100); then RUN.
REQ-040 Branch: branch_taken with FLUSH_CYCLES=1 -> pc_sel=01 with flush=1, then 1 FLUSH cycle with flush=1, then RUN; repeat with FLUSH_CYCLES=0 -> a single flush cycle only.
REQ-041 Simultaneous events: trap_req, branch_taken, dmem_req and ld_use asserted together in RUN -> trap-entry outputs only; then trap_req asserted during MEMWAIT -> ignored until ack.
REQ-042 Reset mid-MEMWAIT: assert rst on wait cycle 5 -> outputs take the reset values immediately; after release state_out=000 and there is no bus_err.

Source files
------------

// File: rtl/msrv32_pipe_ctrl.sv
// Pipeline control for the msrv32 core: stall, flush, memory wait and trap sequencing.
// Outputs are combinational from the current state and inputs; state and counters are registered.
module msrv32_pipe_ctrl #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic       ms_risc32_mp_clk_in,
    input  logic       ms_risc32_mp_rst_in,
    input  logic       branch_taken_in,
    input  logic       ld_use_hazard_in,
    input  logic       dmem_req_in,
    input  logic       dmem_ack_in,
    input  logic       trap_req_in,
    output logic       reg1_en_out,
    output logic       reg2_en_out,
    output logic       reg2_flush_out,
    output logic [1:0] pc_sel_out,
    output logic       trap_taken_out,
    output logic       bus_err_out,
    output logic [2:0] state_out
);

    typedef enum logic [2:0] {
        RUN     = 3'b000,
        LDSTALL = 3'b001,
        MEMWAIT = 3'b010,
        FLUSH   = 3'b011,
        TRAP    = 3'b100
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [1:0] FLUSH_LOAD   = 2'(FLUSH_CYCLES);

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_TRAP   = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic [1:0] flush_cnt;
    logic [1:0] flush_nxt;
    logic       trap_entry;

    always_ff @(posedge ms_risc32_mp_clk_in or posedge ms_risc32_mp_rst_in) begin
        if (ms_risc32_mp_rst_in) begin
            state     <= RUN;
            wait_cnt  <= 8'd0;
            flush_cnt <= 2'd0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        flush_nxt      = flush_cnt;
        trap_entry     = 1'b0;
        reg1_en_out    = 1'b1;
        reg2_en_out    = 1'b1;
        reg2_flush_out = 1'b0;
        pc_sel_out     = PC_PLUS4;
        trap_taken_out = 1'b0;
        bus_err_out    = 1'b0;

        case (state)
            RUN, LDSTALL: begin
                // LDSTALL masks the hazard so a load inserts at most one bubble.
                if (trap_req_in) begin
                    trap_entry = 1'b1;
                end else if (dmem_req_in && !dmem_ack_in) begin
                    reg1_en_out = 1'b0;
                    reg2_en_out = 1'b0;
                    pc_sel_out  = PC_HOLD;
                    wait_nxt    = 8'd0;
                    state_nxt   = MEMWAIT;
                end else if (branch_taken_in) begin
                    reg2_flush_out = 1'b1;
                    pc_sel_out     = PC_BRANCH;
                    if (FLUSH_CYCLES == 0) begin
                        state_nxt = RUN;
                    end else begin
                        flush_nxt = FLUSH_LOAD;
                        state_nxt = FLUSH;
                    end
                end else if (ld_use_hazard_in && state == RUN) begin
                    reg1_en_out    = 1'b0;
                    reg2_flush_out = 1'b1;
                    pc_sel_out     = PC_HOLD;
                    state_nxt      = LDSTALL;
                end else begin
                    state_nxt = RUN;
                end
            end

            MEMWAIT: begin
                wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
                if (dmem_ack_in) begin
                    state_nxt = RUN;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    bus_err_out = 1'b1;
                    trap_entry  = 1'b1;
                end else begin
                    reg1_en_out = 1'b0;
                    reg2_en_out = 1'b0;
                    pc_sel_out  = PC_HOLD;
                end
            end

            FLUSH: begin
                if (trap_req_in) begin
                    trap_entry = 1'b1;
                end else begin
                    reg2_flush_out = 1'b1;
                    if (flush_cnt <= 2'd1) begin
                        flush_nxt = 2'd0;
                        state_nxt = RUN;
                    end else begin
                        flush_nxt = flush_cnt - 2'd1;
                    end
                end
            end

            TRAP: begin
                reg2_flush_out = 1'b1;
                state_nxt      = RUN;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase

        if (trap_entry) begin
            reg1_en_out    = 1'b1;
            reg2_en_out    = 1'b1;
            reg2_flush_out = 1'b1;
            pc_sel_out     = PC_TRAP;
            trap_taken_out = 1'b1;
            state_nxt      = TRAP;
        end

        // Reset holds the pipeline frozen with a bubble in stage 2.
        if (ms_risc32_mp_rst_in) begin
            reg1_en_out    = 1'b0;
            reg2_en_out    = 1'b0;
            reg2_flush_out = 1'b1;
            pc_sel_out     = PC_HOLD;
            trap_taken_out = 1'b0;
            bus_err_out    = 1'b0;
        end
    end

    assign state_out = ms_risc32_mp_rst_in ? RUN : state;

endmodule

// File: tb/tb_msrv32_pipe_ctrl.sv
// Bench for msrv32_pipe_ctrl: three parameterisations driven by shared stimulus and
// checked every cycle against a transaction-level model of the pipeline controller.
module tb_msrv32_pipe_ctrl;

    localparam int N = 3;
    localparam int TMO [N] = '{16, 16, 4};
    localparam int FCY [N] = '{1, 0, 3};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    initial forever #5 clk = ~clk;

    logic trap = 1'b0, br = 1'b0, ld = 1'b0, req = 1'b0, ack = 1'b0;

    logic [N-1:0] r1, r2, fl, tt, be;
    logic [1:0]   pc [N];
    logic [2:0]   st [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        msrv32_pipe_ctrl #(.MEM_TIMEOUT(TMO[g]), .FLUSH_CYCLES(FCY[g])) u_dut (
            .ms_risc32_mp_clk_in(clk),
            .ms_risc32_mp_rst_in(rst),
            .branch_taken_in(br),
            .ld_use_hazard_in(ld),
            .dmem_req_in(req),
            .dmem_ack_in(ack),
            .trap_req_in(trap),
            .reg1_en_out(r1[g]),
            .reg2_en_out(r2[g]),
            .reg2_flush_out(fl[g]),
            .pc_sel_out(pc[g]),
            .trap_taken_out(tt[g]),
            .bus_err_out(be[g]),
            .state_out(st[g])
        );
    end

    // ---------------- model ----------------
    typedef struct {
        bit mem_busy;
        int waited;
        int bubbles_left;
        bit trap_recover;
        bit ld_stalled;
    } mdl_t;

    mdl_t mdl [N];
    logic [9:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    function automatic logic [9:0] act_of(int i);
        return {r1[i], r2[i], fl[i], pc[i], tt[i], be[i], st[i]};
    endfunction

    function automatic void model_step(input mdl_t m, input int tmo, input int fcy,
                                       output logic [9:0] exp, output mdl_t nx);
        bit o_r1, o_r2, o_fl, o_tt, o_be, entry;
        bit [1:0] o_pc;
        int s;
        s = m.mem_busy ? 2 : m.trap_recover ? 4 : (m.bubbles_left > 0) ? 3 : m.ld_stalled ? 1 : 0;
        nx = '{default: 0};
        o_r1 = 1; o_r2 = 1; o_fl = 0; o_pc = 0; o_tt = 0; o_be = 0; entry = 0;
        if (rst) begin
            o_r1 = 0; o_r2 = 0; o_fl = 1; o_pc = 3; s = 0;
        end else if (m.mem_busy) begin
            if (ack) begin
                // access done, back to normal flow
            end else if (m.waited == tmo - 1) begin
                o_be = 1; entry = 1;
            end else begin
                o_r1 = 0; o_r2 = 0; o_pc = 3;
                nx.mem_busy = 1;
                nx.waited = (m.waited < 255) ? m.waited + 1 : 255;
            end
        end else if (m.trap_recover) begin
            o_fl = 1;
        end else if (m.bubbles_left > 0) begin
            if (trap) entry = 1;
            else begin
                o_fl = 1;
                nx.bubbles_left = m.bubbles_left - 1;
            end
        end else begin
            if (trap) entry = 1;
            else if (req && !ack) begin
                o_r1 = 0; o_r2 = 0; o_pc = 3;
                nx.mem_busy = 1; nx.waited = 0;
            end else if (br) begin
                o_fl = 1; o_pc = 1; nx.bubbles_left = fcy;
            end else if (ld && !m.ld_stalled) begin
                o_r1 = 0; o_fl = 1; o_pc = 3; nx.ld_stalled = 1;
            end
        end
        if (entry) begin
            o_r1 = 1; o_r2 = 1; o_fl = 1; o_pc = 2; o_tt = 1;
            nx = '{default: 0};
            nx.trap_recover = 1;
        end
        exp = {o_r1, o_r2, o_fl, o_pc, o_tt, o_be, 3'(s)};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got {r1,r2,fl,pc,tt,be,st}=%b required %b", name, cyc, act, exp);
        end
    endtask

    // Compare all DUTs at the falling edge, then advance the model across the rising edge.
    task automatic cycle();
        logic [9:0] e;
        mdl_t nx [N];
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            model_step(mdl[i], TMO[i], FCY[i], e, nx[i]);
            exp_q.push_back(e);
        end
        for (int i = 0; i < N; i++) begin
            e = exp_q.pop_front();
            check($sformatf("model_dut%0d", i), act_of(i), e);
        end
        for (int i = 0; i < N; i++) mdl[i] = nx[i];
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit t, input bit b, input bit l, input bit rq, input bit ak);
        trap = t; br = b; ld = l; req = rq; ack = ak;
    endtask

    task automatic pin(input string name, input int i, input logic [9:0] exp);
        #1;
        check(name, act_of(i), exp);
    endtask

    localparam logic [9:0] V_RESET  = 10'b0_0_1_11_0_0_000;
    localparam logic [9:0] V_NORMAL = 10'b1_1_0_00_0_0_000;

    initial begin
        for (int i = 0; i < N; i++) mdl[i] = '{default: 0};
        @(posedge clk);
        #1;
        pin("reset_vals", 0, V_RESET);
        cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        pin("idle_normal", 0, V_NORMAL);
        cycle();

        // load-use held two cycles: one bubble only
        drive(0, 0, 1, 0, 0);
        pin("lduse_c1", 0, 10'b0_1_1_11_0_0_000);
        cycle();
        pin("lduse_c2", 0, 10'b1_1_0_00_0_0_001);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();

        // memory wait, ack three cycles after request
        drive(0, 0, 0, 1, 0);
        pin("mem_req", 0, 10'b0_0_0_11_0_0_000);
        cycle();
        pin("mem_wait1", 0, 10'b0_0_0_11_0_0_010);
        cycle();
        cycle();
        drive(0, 0, 0, 1, 1);
        pin("mem_ack", 0, 10'b1_1_0_00_0_0_010);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cycle();

        // timeout: bus error on MEMWAIT cycle 16
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k < 16; k++) cycle();
        pin("timeout", 0, 10'b1_1_1_10_1_1_010);
        cycle();
        pin("trap_state", 0, 10'b1_1_1_00_0_0_100);
        cycle();
        pin("after_trap", 0, V_NORMAL);
        for (int k = 0; k < 6; k++) cycle();

        // branch with FLUSH_CYCLES=1 (dut0) and 0 (dut1)
        drive(0, 1, 0, 0, 0);
        pin("br_a", 0, 10'b1_1_1_01_0_0_000);
        pin("br_b", 1, 10'b1_1_1_01_0_0_000);
        cycle();
        drive(0, 0, 0, 0, 0);
        pin("flush_a", 0, 10'b1_1_1_00_0_0_011);
        pin("flush_b", 1, V_NORMAL);
        cycle();
        pin("post_flush_a", 0, V_NORMAL);
        for (int k = 0; k < 4; k++) cycle();

        // every event at once: trap wins
        drive(1, 1, 1, 1, 0);
        pin("all_events", 0, 10'b1_1_1_10_1_0_000);
        cycle();
        drive(0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(1, 1, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            pin("trap_in_memwait", 0, 10'b0_0_0_11_0_0_010);
            cycle();
        end
        drive(0, 0, 0, 0, 1);
        pin("memwait_ack", 0, 10'b1_1_0_00_0_0_010);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) cycle();

        // reset on wait cycle 5
        drive(0, 0, 0, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0);
        for (int k = 1; k < 5; k++) cycle();
        rst = 1'b1;
        pin("rst_midwait", 0, V_RESET);
        cycle();
        rst = 1'b0;
        pin("rst_release", 0, V_NORMAL);
        for (int k = 0; k < 24; k++) cycle();

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
